// File: rtl/md_unit_if.sv
// md_unit_if: E-stage multiply/divide request and result bundle.
// The pipeline side drives the request; md_unit answers on the slave side.
interface md_unit_if;
    logic        E_start;
    logic [2:0]  E_mdOp;
    logic [31:0] E_srcA;
    logic [31:0] E_srcB;
    logic        D_isMd;
    logic        E_busy;
    logic [31:0] E_mdOut;
    logic        D_mdStall;
    logic [31:0] E_hi;
    logic [31:0] E_lo;

    modport master (
        output E_start, E_mdOp, E_srcA, E_srcB, D_isMd,
        input  E_busy, E_mdOut, D_mdStall, E_hi, E_lo
    );

    modport slave (
        input  E_start, E_mdOp, E_srcA, E_srcB, D_isMd,
        output E_busy, E_mdOut, D_mdStall, E_hi, E_lo
    );
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle MULT/DIV unit owning HI/LO, with stall request.
// Optional macro MDU_EARLY_OUT_EN: zero-operand ops finish in one cycle.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       rst_n,
    md_unit_if.slave  bus
);
    localparam int MAXC =
        (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);

    typedef logic [CW-1:0] cnt_t;
    typedef enum logic {IDLE, RUN} state_t;

    localparam cnt_t MULT_N = cnt_t'(MULT_CYCLES);
    localparam cnt_t DIV_N  = cnt_t'(DIV_CYCLES);
    localparam cnt_t ONE_N  = cnt_t'(1);

    state_t      state, nextState;
    cnt_t        cnt;
    cnt_t        loadN;
    logic [31:0] hi, lo;
    logic [63:0] res;
    logic        resWr;
    logic [63:0] calc;
    logic        calcWr;

    logic [31:0] a, b;
    logic        isArith;
    logic        isMult, isMultu, isDiv, isDivu;
    logic        bZero, aZero, divOvf;
    logic signed [63:0] sA64, sB64;
    logic signed [31:0] sA, sB;

    assign a       = bus.E_srcA;
    assign b       = bus.E_srcB;
    assign isArith = ~bus.E_mdOp[2];
    assign isMult  = bus.E_mdOp == 3'd0;
    assign isMultu = bus.E_mdOp == 3'd1;
    assign isDiv   = bus.E_mdOp == 3'd2;
    assign isDivu  = bus.E_mdOp == 3'd3;
    assign aZero   = a == 32'd0;
    assign bZero   = b == 32'd0;
    assign divOvf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign sA      = a;
    assign sB      = b;
    assign sA64    = {{32{a[31]}}, a};
    assign sB64    = {{32{b[31]}}, b};

    // Result and busy length of the op being presented in E
    always_comb begin
        calc   = '0;
        calcWr = 1'b1;
        loadN  = MULT_N;
        unique case (1'b1)
            isMult:  calc = sA64 * sB64;
            isMultu: calc = {32'd0, a} * {32'd0, b};
            isDiv: begin
                loadN = DIV_N;
                if (bZero) begin
                    calcWr = 1'b0;
                end else if (divOvf) begin
                    calc = {32'd0, 32'h8000_0000};
                end else begin
                    calc = {32'(sA % sB), 32'(sA / sB)};
                end
            end
            isDivu: begin
                loadN = DIV_N;
                if (bZero) calcWr = 1'b0;
                else       calc = {a % b, a / b};
            end
            default: calcWr = 1'b0;
        endcase
`ifdef MDU_EARLY_OUT_EN
        if ((isMult || isMultu) && (aZero || bZero)) begin
            loadN = ONE_N;
            calc  = '0;
        end
        if ((isDiv || isDivu) && bZero) loadN = ONE_N;
`endif
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    // FSM next state
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (bus.E_start && isArith) nextState = RUN;
            RUN:  if (cnt == ONE_N)           nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Counter, pending result and HI/LO updates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            res   <= '0;
            resWr <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else if (state == IDLE) begin
            if (bus.E_start && isArith) begin
                cnt   <= loadN;
                res   <= calc;
                resWr <= calcWr;
            end else if (bus.E_start && bus.E_mdOp == 3'd4) begin
                hi <= a;
            end else if (bus.E_start && bus.E_mdOp == 3'd5) begin
                lo <= a;
            end
        end else begin
            cnt <= cnt - ONE_N;
            if (cnt == ONE_N && resWr) begin
                hi    <= res[63:32];
                lo    <= res[31:0];
                resWr <= 1'b0;
            end
        end
    end

    assign bus.E_busy    = state == RUN;
    assign bus.E_hi      = hi;
    assign bus.E_lo      = lo;
    assign bus.E_mdOut   = (bus.E_mdOp == 3'd6) ? hi :
                           (bus.E_mdOp == 3'd7) ? lo : 32'd0;
    assign bus.D_mdStall = bus.D_isMd &
                           (bus.E_busy | (bus.E_start & isArith));
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and random checks of md_unit against
// a plain-arithmetic HI/LO model.
module tb_md_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;

    md_unit_if bus ();

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: apply op to mHi/mLo, return expected busy length
    function automatic int model(input logic [2:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
        logic [63:0] p;
        longint sa, sb, q, r;
        int n;
        n = (op < 3'd2) ? MC : DC;
`ifdef MDU_EARLY_OUT_EN
        if (op < 3'd2 && (a == 0 || b == 0)) n = 1;
        if ((op == 3'd2 || op == 3'd3) && b == 0) n = 1;
`endif
        case (op)
            3'd0: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p = 64'(sa * sb);
                {mHi, mLo} = p;
            end
            3'd1: begin
                p = {32'd0, a} * {32'd0, b};
                {mHi, mLo} = p;
            end
            3'd2, 3'd3: begin
                if (b != 0) begin
                    sa = (op == 3'd2) ? longint'($signed(a))
                                      : longint'({32'd0, a});
                    sb = (op == 3'd2) ? longint'($signed(b))
                                      : longint'({32'd0, b});
                    q = sa / sb;
                    r = sa % sb;
                    mLo = q[31:0];
                    mHi = r[31:0];
                end
            end
            3'd4: mHi = a;
            3'd5: mLo = a;
            default: ;
        endcase
        return (op < 3'd4) ? n : 0;
    endfunction

    task automatic drive(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic isMd);
        bus.E_start = 1'b1;
        bus.E_mdOp = op;
        bus.E_srcA = a;
        bus.E_srcB = b;
        bus.D_isMd = isMd;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int cyc);
        drive(op, a, b, 1'b0);
        step();
        bus.E_start = 1'b0;
        cyc = 0;
        while (bus.E_busy && cyc < 200) begin
            cyc++;
            step();
        end
    endtask

    task automatic check_hilo(input string name, input int cyc,
                              input int expCyc);
        checks++;
        if (cyc !== expCyc) begin
            failures++;
            $display("FAIL %s busy: got %0d want %0d", name, cyc, expCyc);
        end
        checks++;
        if (bus.E_hi !== mHi || bus.E_lo !== mLo) begin
            failures++;
            $display("FAIL %s hilo: got %h_%h want %h_%h",
                     name, bus.E_hi, bus.E_lo, mHi, mLo);
        end
    endtask

    task automatic test_reset();
        int c;
        run_op(3'd4, 32'h55, 32'h0, c);
        drive(3'd0, 32'd3, 32'd4, 1'b0);
        step();
        bus.E_start = 1'b0;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.E_busy !== 1'b0 || bus.E_hi !== 0 || bus.E_lo !== 0) begin
            failures++;
            $display("FAIL reset_async: busy=%b hi=%h lo=%h want 0",
                     bus.E_busy, bus.E_hi, bus.E_lo);
        end
        step();
        rst_n = 1'b1;
        mHi = '0;
        mLo = '0;
        repeat (8) step();
        checks++;
        if (bus.E_busy !== 1'b0 || bus.E_hi !== 0 || bus.E_lo !== 0) begin
            failures++;
            $display("FAIL reset_abort: busy=%b hi=%h lo=%h want 0",
                     bus.E_busy, bus.E_hi, bus.E_lo);
        end
        drive(3'd6, 32'h0, 32'h0, 1'b0);
        #1;
        checks++;
        if (bus.E_mdOut !== 32'd0) begin
            failures++;
            $display("FAIL reset_mfhi: got %h want 0", bus.E_mdOut);
        end
        step();
        bus.E_start = 1'b0;
    endtask

    task automatic test_mult();
        int c, e;
        e = model(3'd0, 32'd3, 32'hFFFF_FFFE);
        run_op(3'd0, 32'd3, 32'hFFFF_FFFE, c);
        check_hilo("mult", c, e);
        checks++;
        if (bus.E_hi !== 32'hFFFF_FFFF || bus.E_lo !== 32'hFFFF_FFFA) begin
            failures++;
            $display("FAIL mult_const: got %h_%h want ffffffff_fffffffa",
                     bus.E_hi, bus.E_lo);
        end
        e = model(3'd1, 32'd3, 32'hFFFF_FFFE);
        run_op(3'd1, 32'd3, 32'hFFFF_FFFE, c);
        check_hilo("multu", c, e);
        checks++;
        if (bus.E_hi !== 32'h2 || bus.E_lo !== 32'hFFFF_FFFA) begin
            failures++;
            $display("FAIL multu_const: got %h_%h want 00000002_fffffffa",
                     bus.E_hi, bus.E_lo);
        end
    endtask

    task automatic test_div();
        int c, e;
        e = model(3'd2, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, c);
        check_hilo("div", c, e);
        checks++;
        if (bus.E_hi !== 32'hFFFF_FFFF || bus.E_lo !== 32'hFFFF_FFFD) begin
            failures++;
            $display("FAIL div_const: got %h_%h want ffffffff_fffffffd",
                     bus.E_hi, bus.E_lo);
        end
        e = model(3'd3, 32'd7, 32'd2);
        run_op(3'd3, 32'd7, 32'd2, c);
        check_hilo("divu", c, e);
        e = model(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, c);
        check_hilo("div_ovf", c, e);
        checks++;
        if (bus.E_hi !== 32'h0 || bus.E_lo !== 32'h8000_0000) begin
            failures++;
            $display("FAIL div_ovf_const: got %h_%h want 0_80000000",
                     bus.E_hi, bus.E_lo);
        end
    endtask

    task automatic test_stall();
        int n;
        logic want;
        for (int m = 1; m >= 0; m--) begin
            want = (m == 1);
            drive(3'd0, 32'd5, 32'd6, want);
            #1;
            checks++;
            if (bus.D_mdStall !== want) begin
                failures++;
                $display("FAIL stall_start: got %b want %b",
                         bus.D_mdStall, want);
            end
            void'(model(3'd0, 32'd5, 32'd6));
            step();
            bus.E_start = 1'b0;
            n = 0;
            while (bus.E_busy && n < 200) begin
                checks++;
                if (bus.D_mdStall !== want) begin
                    failures++;
                    $display("FAIL stall_busy: cyc %0d got %b want %b",
                             n, bus.D_mdStall, want);
                end
                n++;
                step();
            end
            checks++;
            if (bus.D_mdStall !== 1'b0 || n != MC) begin
                failures++;
                $display("FAIL stall_end: stall=%b busy=%0d want 0/%0d",
                         bus.D_mdStall, n, MC);
            end
        end
        bus.D_isMd = 1'b0;
    endtask

    task automatic test_mt_ignore();
        int n, e;
        drive(3'd4, 32'h1234_5678, 32'h0, 1'b0);
        void'(model(3'd4, 32'h1234_5678, 32'h0));
        step();
        bus.E_start = 1'b0;
        checks++;
        if (bus.E_hi !== 32'h1234_5678 || bus.E_busy !== 1'b0) begin
            failures++;
            $display("FAIL mthi: hi=%h busy=%b want 12345678/0",
                     bus.E_hi, bus.E_busy);
        end
        e = model(3'd0, 32'h0001_0003, 32'h0002_0007);
        drive(3'd0, 32'h0001_0003, 32'h0002_0007, 1'b0);
        step();
        drive(3'd5, 32'hDEAD_BEEF, 32'h0, 1'b0);
        step();
        bus.E_start = 1'b0;
        n = 2;
        while (bus.E_busy && n < 200) begin
            n++;
            step();
        end
        check_hilo("mtlo_ignored", n - 1, e);
    endtask

    task automatic test_divzero();
        int c, e;
        run_op(3'd4, 32'hA, 32'h0, c);
        run_op(3'd5, 32'hB, 32'h0, c);
        void'(model(3'd4, 32'hA, 32'h0));
        void'(model(3'd5, 32'hB, 32'h0));
        e = model(3'd2, 32'd99, 32'd0);
        run_op(3'd2, 32'd99, 32'd0, c);
        check_hilo("div_zero", c, e);
        e = model(3'd3, 32'd99, 32'd0);
        run_op(3'd3, 32'd99, 32'd0, c);
        check_hilo("divu_zero", c, e);
        e = model(3'd0, 32'd0, 32'h777);
        run_op(3'd0, 32'd0, 32'h777, c);
        check_hilo("mult_zero", c, e);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [2:0] op;
        logic [31:0] a, b;
        logic md;
        int c, e;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            md = 1'($urandom_range(0, 1));
            drive(op, a, b, md);
            #1;
            checks++;
            if (bus.D_mdStall !== (md && op < 3'd4)) begin
                failures++;
                $display("FAIL rnd_stall %0d: op %0d got %b",
                         i, op, bus.D_mdStall);
            end
            if (op >= 3'd6) begin
                checks++;
                if (bus.E_mdOut !== ((op == 3'd6) ? mHi : mLo)) begin
                    failures++;
                    $display("FAIL rnd_mf %0d: op %0d got %h want %h",
                             i, op, bus.E_mdOut,
                             (op == 3'd6) ? mHi : mLo);
                end
            end
            e = model(op, a, b);
            step();
            bus.E_start = 1'b0;
            bus.D_isMd = 1'b0;
            c = 0;
            while (bus.E_busy && c < 200) begin
                c++;
                step();
            end
            check_hilo($sformatf("rnd%0d_op%0d", i, op), c, e);
        end
    endtask

    initial begin
        bus.E_start = 1'b0;
        bus.E_mdOp = 3'd0;
        bus.E_srcA = '0;
        bus.E_srcB = '0;
        bus.D_isMd = 1'b0;
        #1;
        checks++;
        if (bus.E_busy !== 1'b0 || bus.E_hi !== 0 || bus.E_lo !== 0) begin
            failures++;
            $display("FAIL reset_init: busy=%b hi=%h lo=%h want 0",
                     bus.E_busy, bus.E_hi, bus.E_lo);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_mt_ignore();
        test_divzero();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
